multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle RV32I core. Sequences the datapath one instruction at a time.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// State enum, opcode values, ALUOp and datapath mux select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch,
        StJal,
        StJalr,
        StTrap
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // States that hold a request on the shared memory port.
    function automatic logic is_mem_state(state_t s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles and flags when the stall limit is reached.
// TIMEOUT = 0 disables the limit entirely.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    // Saturate at the limit so the count can never wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and handshakes with the shared memory port. Outputs are Moore, with mem_ready gating in mem states.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             trap,
    output logic             trap_cause
);

    state_t           state_q, state_d;
    logic             trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0] retired_q;
    logic             wait_clear;
    logic             wait_count;
    logic             wait_expired;

    assign wait_clear = is_mem_state(state_d) && (state_d != state_q);
    assign wait_count = mem_req && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .count  (wait_count),
        .expired(wait_expired)
    );

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCSrc        = 1'b0;
        ALUOp        = ALUOP_ADD;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        RegWrite     = 1'b0;
        MemtoReg     = WB_ALUOUT;
        instr_done   = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_R:               state_d = StExecR;
                    OP_I:               state_d = StExecI;
                    OP_LOAD, OP_STORE:  state_d = StAddr;
                    OP_BRANCH:          state_d = StBranch;
                    OP_JAL:             state_d = StJal;
                    OP_JALR:            state_d = StJalr;
                    default: begin
                        state_d      = StTrap;
                        trap_cause_d = 1'b0;
                    end
                endcase
            end
            StExecR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_R;
                state_d = StWbAlu;
            end
            StExecI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_I;
                state_d = StWbAlu;
            end
            StAddr: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StWbAlu: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StWbMem: begin
                RegWrite   = 1'b1;
                MemtoReg   = WB_MDR;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ALUSrcA     = SRCA_RS1;
                ALUSrcB     = SRCB_RS2;
                ALUOp       = ALUOP_BR;
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
                instr_done  = 1'b1;
                state_d     = StFetch;
            end
            StJal: begin
                PCWrite    = 1'b1;
                PCSrc      = 1'b1;
                RegWrite   = 1'b1;
                MemtoReg   = WB_PC;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                MemtoReg   = WB_PC;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase

        // A completing handshake beats the timeout in the same cycle.
        if (is_mem_state(state_q) && !mem_ready && wait_expired) begin
            state_d      = StTrap;
            trap_cause_d = 1'b1;
        end

        // Strobes must fall the moment reset rises, before any clock edge.
        if (reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            trap_cause_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign retired    = retired_q;
    assign trap       = (state_q == StTrap);
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a memory responder feeds opcodes and wait states,
// a monitor tallies strobes per instruction and checks them against a per-instruction model.
module tb_multicycle_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int RMOD    = 16;

    logic             clk;
    logic             reset;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCSrc;
    logic [1:0]       ALUOp;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic [1:0]       MemtoReg;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic             trap_cause;

    multicycle_ctrl #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .instr_done (instr_done),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cycles;
        int mreq;
        int mwe;
        int iord;
        int regw;
        int m2r;
        int pcw;
        int pcwc;
        int aluset;
        int ret;
    } exp_t;

    exp_t       expq[$];
    int         waitq[$];
    logic [6:0] imemq[$];
    int         total = 0;
    int         bad = 0;
    int         model_ret = 0;
    bit         ir_load = 1'b0;

    logic [6:0] ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-instruction totals derived from the instruction class and the memory wait states.
    function automatic exp_t model(logic [6:0] op, int w1, int w2, int ret);
        exp_t e;
        bit r = (op == 7'h33);
        bit i = (op == 7'h13);
        bit l = (op == 7'h03);
        bit s = (op == 7'h23);
        bit b = (op == 7'h63);
        bit j = (op == 7'h6F) || (op == 7'h67);
        bit m = l || s;
        e.cycles = w1 + ((b || j) ? 3 : 4) + (l ? 1 : 0) + (m ? w2 : 0);
        e.mreq   = w1 + 1 + (m ? w2 + 1 : 0);
        e.mwe    = s ? w2 + 1 : 0;
        e.iord   = m ? w2 + 1 : 0;
        e.regw   = (s || b) ? 0 : 1;
        e.m2r    = l ? 1 : (j ? 2 : 0);
        e.pcw    = j ? 2 : 1;
        e.pcwc   = b ? 1 : 0;
        e.aluset = 1 | (b ? 2 : 0) | (r ? 4 : 0) | (i ? 8 : 0);
        e.ret    = ret;
        return e;
    endfunction

    task automatic issue(input logic [6:0] op, input int w1, input int w2);
        imemq.push_back(op);
        waitq.push_back(w1);
        if (op == 7'h03 || op == 7'h23) waitq.push_back(w2);
        expq.push_back(model(op, w1, w2, model_ret));
        model_ret = (model_ret + 1) % RMOD;
    endtask

    task automatic begin_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        expq.delete();
        waitq.delete();
        imemq.delete();
        model_ret = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (expq.size() == 0) break;
            @(negedge clk);
        end
        if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    endtask

    // Memory responder: one wait count per request, random mem_ready while idle.
    initial begin
        int k;
        int w;
        bit have;
        k = 0;
        w = 0;
        have = 1'b0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                have = 1'b0;
                k = 0;
                mem_ready = 1'b0;
                ir_load = 1'b0;
            end else begin
                if (ir_load) begin
                    opcode = (imemq.size() > 0) ? imemq.pop_front() : 7'h00;
                    ir_load = 1'b0;
                end
                if (mem_req) begin
                    if (!have && waitq.size() > 0) begin
                        w = waitq.pop_front();
                        have = 1'b1;
                        k = 0;
                    end
                    if (have && k == w) begin
                        mem_ready = 1'b1;
                        have = 1'b0;
                    end else begin
                        mem_ready = 1'b0;
                        k++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: tallies strobes over each instruction and scores them on instr_done.
    initial begin
        int cyc, mreq, mwe, iord, regw, m2r, pcw, pcwc, aluset;
        exp_t e;
        cyc = 0; mreq = 0; mwe = 0; iord = 0; regw = 0; m2r = 0; pcw = 0; pcwc = 0; aluset = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; mreq = 0; mwe = 0; iord = 0; regw = 0; m2r = 0; pcw = 0; pcwc = 0;
                aluset = 0;
            end else if (!trap) begin
                cyc++;
                if (mem_req) mreq++;
                if (mem_we) mwe++;
                if (IorD) iord++;
                if (RegWrite) begin
                    regw++;
                    m2r = int'(MemtoReg);
                end
                if (PCWrite) pcw++;
                if (PCWriteCond) pcwc++;
                aluset = aluset | (1 << ALUOp);
                if (IRWrite) ir_load = 1'b1;
                if (instr_done) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("latency", cyc, e.cycles);
                        chk("mem_req_cycles", mreq, e.mreq);
                        chk("mem_we_cycles", mwe, e.mwe);
                        chk("iord_cycles", iord, e.iord);
                        chk("regwrite_cycles", regw, e.regw);
                        if (e.regw != 0) chk("memtoreg", m2r, e.m2r);
                        chk("pcwrite_cycles", pcw, e.pcw);
                        chk("pcwritecond_cycles", pcwc, e.pcwc);
                        chk("aluop_set", aluset, e.aluset);
                        chk("retired", int'(retired), e.ret);
                    end
                    cyc = 0; mreq = 0; mwe = 0; iord = 0; regw = 0; m2r = 0; pcw = 0; pcwc = 0;
                    aluset = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        int n;
        logic [6:0] op;
        int w1;
        reset = 1'b1;
        opcode = 7'h00;

        // Reset values while reset is held in FETCH.
        begin_reset();
        @(negedge clk);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_irwrite", int'(IRWrite), 0);
        chk("rst_pcwrite", int'(PCWrite), 0);
        chk("rst_regwrite", int'(RegWrite), 0);
        chk("rst_instr_done", int'(instr_done), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_trap", int'(trap), 0);
        chk("rst_trap_cause", int'(trap_cause), 0);

        ir = 32'h002081B3; issue(ir[6:0], 0, 0);
        ir = 32'h0080A283; issue(ir[6:0], 0, 3);
        ir = 32'h00208463; issue(ir[6:0], 0, 0);
        issue(7'h33, 8, 0);
        issue(7'h23, 1, 8);
        issue(7'h6F, 0, 0);
        issue(7'h67, 2, 0);
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 6)];
            w1 = ($urandom_range(0, 9) == 0) ? 8 : $urandom_range(0, 3);
            issue(op, w1, $urandom_range(0, 4));
        end
        release_reset();
        drain(4000);

        // Reset asserted in the middle of a store wait.
        begin_reset();
        issue(7'h33, 0, 0);
        issue(7'h13, 0, 0);
        imemq.push_back(7'h23);
        waitq.push_back(0);
        waitq.push_back(6);
        release_reset();
        n = 0;
        while (!mem_we && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("store_wait_seen", int'(mem_we), 1);
        chk("store_retired_before", int'(retired), 2);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req", int'(mem_req), 0);
        chk("async_mem_we", int'(mem_we), 0);
        chk("async_retired", int'(retired), 0);
        begin_reset();
        issue(7'h33, 0, 0);
        release_reset();
        @(negedge clk);
        chk("post_rst_fetch", int'(mem_req), 1);
        chk("post_rst_retired", int'(retired), 0);
        drain(100);

        // Illegal opcode after one legal instruction.
        begin_reset();
        issue(7'h33, 0, 0);
        imemq.push_back(7'h7F);
        waitq.push_back(0);
        release_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trap && n < 30);
        chk("illegal_trap_cycle", n, 7);
        chk("illegal_trap", int'(trap), 1);
        chk("illegal_cause", int'(trap_cause), 0);
        repeat (3) begin
            @(negedge clk);
            chk("illegal_mem_req", int'(mem_req), 0);
        end
        chk("illegal_retired", int'(retired), 1);
        chk("illegal_pending", expq.size(), 0);

        // Fetch that never completes runs into the timeout.
        begin_reset();
        release_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trap && n < 40);
        chk("timeout_cycle", n, TIMEOUT + 2);
        chk("timeout_trap", int'(trap), 1);
        chk("timeout_cause", int'(trap_cause), 1);
        chk("timeout_mem_req", int'(mem_req), 0);
        @(negedge clk);
        chk("timeout_sticky", int'(trap), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
